// File: rtl/mem_stage_sram_responder.sv
// Serves 32-bit MEM-stage loads/stores from a 16-bit asynchronous SRAM as two half-word phases.
// ready stays low while an access is in flight and doubles as the pipeline stall source.
module mem_stage_sram_responder #(
  parameter logic [31:0] BASE_ADDR     = 32'd1024,
  parameter int          ACCESS_CYCLES = 2,
  parameter int          SRAM_AW       = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read_en,
  input  logic               mem_write_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  // state  | meaning
  // IDLE   | waiting for a request; latches it on the clock edge it is seen
  // LOW    | half-word {word,0} on the bus for ACCESS_CYCLES cycles
  // HIGH   | half-word {word,1} on the bus for ACCESS_CYCLES cycles
  // DONE   | one-cycle completion, ready=1, requests not sampled
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               is_wr_q, is_wr_d;
  logic [31:0]        read_data_q, read_data_d;

  logic [31:0] offset;
  logic        req;
  logic        last;
  logic        high_half;
  logic        unused_offset_bits;

  assign offset             = address - BASE_ADDR;
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};
  assign req                = mem_read_en | mem_write_en;
  assign last               = (cnt_q == '0);
  assign high_half          = (state_q == S_HIGH);
  assign read_data          = read_data_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    read_data_d = read_data_q;
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;

    case (state_q)
      S_IDLE: begin
        ready = ~req;
        if (req) begin
          word_d  = offset[SRAM_AW:2];
          wdata_d = write_data;
          is_wr_d = mem_write_en;
          cnt_d   = CNT_LOAD;
          state_d = S_LOW;
        end
      end
      S_LOW, S_HIGH: begin
        sram_addr = {word_q, high_half};
        if (is_wr_q) begin
          sram_dq_out = high_half ? wdata_q[31:16] : wdata_q[15:0];
          sram_dq_oe  = 1'b1;
          // WE rises one cycle early so address/data hold past the rising edge
          sram_we_n   = last && (ACCESS_CYCLES > 1);
        end else begin
          sram_oe_n = 1'b0;
          if (last) begin
            if (high_half) read_data_d[31:16] = sram_dq_in;
            else           read_data_d[15:0]  = sram_dq_in;
          end
        end
        if (last) begin
          cnt_d   = CNT_LOAD;
          state_d = high_half ? S_DONE : S_HIGH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        ready   = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      wdata_q     <= '0;
      is_wr_q     <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      is_wr_q     <= is_wr_d;
      read_data_q <= read_data_d;
    end
  end

endmodule
